// File: rtl/clock.sv
// rtl/clock.sv - I2C SCL generator with clock stretching, multi-master sync and stuck-bus detect
//
// Ports:
//   clk_in    in    system clock
//   rst_n     in    asynchronous active-low reset
//   scl       inout open-drain SCL, only ever driven 1'b0 or released to 1'bz
//   bus_clear out   high while SCL is held low past the WAIT_END timeout
//
// The phase counter is named `counter` so the master controller (and benches)
// can time SDA changes from it.
module clock #(
  parameter int COUNTER_END  = 5,
  parameter int COUNTER_RISE = 2,
  parameter int MULTI_MASTER = 0,
  parameter int WAIT_END     = 100
) (
  input  logic clk_in,
  input  logic rst_n,
  inout  wire  scl,
  output logic bus_clear
);

  localparam int CW = $clog2(COUNTER_END);
  localparam int WW = $clog2(WAIT_END + 1);

  localparam logic [CW-1:0] RISE     = CW'(COUNTER_RISE);
  localparam logic [CW-1:0] LAST     = CW'(COUNTER_END - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_END);
  localparam logic [WW-1:0] WAIT_PRE = WW'(WAIT_END - 1);

  logic [CW-1:0] counter;
  logic [WW-1:0] r_wait_counter;
  logic          w_line_high;
  logic          w_stretch;
  logic          w_sync;

  // Open-drain pad: pull low during the low phase, release otherwise.
  assign scl = (counter < RISE) ? 1'b0 : 1'bz;

  // A released, pulled-up line reads high; anything not a solid 0 counts as high.
  assign w_line_high = (scl !== 1'b0);

  // At the rise point a low line means a slave (or slower master) is stretching.
  assign w_stretch = (counter == RISE) && !w_line_high;

  // Another master pulling low during our high phase starts a new period for both.
  assign w_sync = (MULTI_MASTER != 0) && (counter > RISE) && (counter < LAST)
                  && !w_line_high;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      counter        <= '0;
      r_wait_counter <= '0;
      bus_clear      <= 1'b0;
    end else if (w_stretch) begin
      counter <= counter;
      if (r_wait_counter != WAIT_MAX) begin
        r_wait_counter <= r_wait_counter + WW'(1);
      end
      // Flag on the same edge the wait count reaches WAIT_END.
      if (r_wait_counter >= WAIT_PRE) begin
        bus_clear <= 1'b1;
      end
    end else begin
      r_wait_counter <= '0;
      // Only leaving the stretch state (line seen high) can get us here while stuck.
      bus_clear      <= 1'b0;
      if (w_sync) begin
        counter <= '0;
      end else if (counter == LAST) begin
        counter <= '0;
      end else begin
        counter <= counter + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock.sv
// tb/tb_clock.sv - self-checking bench for the I2C SCL generator
module tb_clock;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic r_pull_mm = 1'b0;
  logic r_pull_sm = 1'b0;
  logic bus_clear_mm;
  logic bus_clear_sm;
  wire  scl_mm;
  wire  scl_sm;

  int n_pass  = 0;
  int n_total = 0;

  pullup (scl_mm);
  pullup (scl_sm);

  assign scl_mm = r_pull_mm ? 1'b0 : 1'bz;
  assign scl_sm = r_pull_sm ? 1'b0 : 1'bz;

  always #5 clk_in = ~clk_in;

  clock #(.COUNTER_END(5), .COUNTER_RISE(2), .MULTI_MASTER(1), .WAIT_END(100)) u_mm (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .scl       (scl_mm),
    .bus_clear (bus_clear_mm)
  );

  clock #(.COUNTER_END(5), .COUNTER_RISE(2), .MULTI_MASTER(0), .WAIT_END(100)) u_sm (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .scl       (scl_sm),
    .bus_clear (bus_clear_sm)
  );

  task automatic wait_mm(input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (u_mm.counter == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd0) $display("FAIL reset_counter got %0d want 0", u_mm.counter); else n_pass++;
    n_total++; if (scl_mm !== 1'b0) $display("FAIL reset_scl got %b want 0", scl_mm); else n_pass++;
    n_total++; if (bus_clear_mm !== 1'b0) $display("FAIL reset_bus_clear got %b want 0", bus_clear_mm); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd1 || scl_mm !== 1'b0) $display("FAIL reset_rel1 got cnt=%0d scl=%b want cnt=1 scl=0", u_mm.counter, scl_mm); else n_pass++;
    @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd2 || scl_mm !== 1'b1) $display("FAIL reset_rel2 got cnt=%0d scl=%b want cnt=2 scl=1", u_mm.counter, scl_mm); else n_pass++;
  endtask

  task automatic test_free_run;
    bit ok;
    logic exp_scl;
    int   exp_cnt;
    wait_mm(0, ok);
    n_total++; if (!ok) $display("FAIL free_sync got timeout want counter=0"); else n_pass++;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_in);
      exp_cnt = i % 5;
      exp_scl = (exp_cnt < 2) ? 1'b0 : 1'b1;
      n_total++; if (u_mm.counter != exp_cnt) $display("FAIL free_counter step %0d got %0d want %0d", i, u_mm.counter, exp_cnt); else n_pass++;
      n_total++; if (scl_mm !== exp_scl) $display("FAIL free_scl step %0d got %b want %b", i, scl_mm, exp_scl); else n_pass++;
      n_total++; if (bus_clear_mm !== 1'b0) $display("FAIL free_bus_clear step %0d got %b want 0", i, bus_clear_mm); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_mm(3, ok);
    n_total++; if (!ok) $display("FAIL mid_sync got timeout want counter=3"); else n_pass++;
    n_total++; if (scl_mm !== 1'b1) $display("FAIL mid_pre_scl got %b want 1", scl_mm); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (scl_mm !== 1'b0) $display("FAIL mid_async_scl got %b want 0", scl_mm); else n_pass++;
    n_total++; if (u_mm.counter !== 3'd0) $display("FAIL mid_async_counter got %0d want 0", u_mm.counter); else n_pass++;
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    n_total++; if (scl_mm !== 1'b0) $display("FAIL mid_rel1_scl got %b want 0", scl_mm); else n_pass++;
    @(negedge clk_in);
    n_total++; if (scl_mm !== 1'b1 || u_mm.counter !== 3'd2) $display("FAIL mid_rel2 got scl=%b cnt=%0d want scl=1 cnt=2", scl_mm, u_mm.counter); else n_pass++;
  endtask

  task automatic test_multi_master;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_mm(3, ok);
    n_total++; if (!ok || u_sm.counter !== 3'd3) $display("FAIL mm_sync got ok=%0d sm_cnt=%0d want ok=1 sm_cnt=3", ok, u_sm.counter); else n_pass++;
    r_pull_mm = 1'b1;
    r_pull_sm = 1'b1;
    @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd0) $display("FAIL mm_restart got %0d want 0", u_mm.counter); else n_pass++;
    n_total++; if (u_sm.counter !== 3'd4) $display("FAIL sm_ignore got %0d want 4", u_sm.counter); else n_pass++;
    r_pull_mm = 1'b0;
    r_pull_sm = 1'b0;
    #1;
    n_total++; if (scl_mm !== 1'b0) $display("FAIL mm_low0_scl got %b want 0", scl_mm); else n_pass++;
    n_total++; if (scl_sm !== 1'b1) $display("FAIL sm_high_scl got %b want 1", scl_sm); else n_pass++;
    @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd1 || scl_mm !== 1'b0) $display("FAIL mm_low1 got cnt=%0d scl=%b want cnt=1 scl=0", u_mm.counter, scl_mm); else n_pass++;
    n_total++; if (u_sm.counter !== 3'd0) $display("FAIL sm_wrap got %0d want 0", u_sm.counter); else n_pass++;
    @(negedge clk_in);
    n_total++; if (u_mm.counter !== 3'd2 || scl_mm !== 1'b1) $display("FAIL mm_rise got cnt=%0d scl=%b want cnt=2 scl=1", u_mm.counter, scl_mm); else n_pass++;
    n_total++; if (u_sm.counter !== 3'd1) $display("FAIL sm_next got %0d want 1", u_sm.counter); else n_pass++;
  endtask

  task automatic test_stretch;
    bit ok;
    int cyc;
    wait_mm(0, ok);
    n_total++; if (!ok) $display("FAIL st_sync got timeout want counter=0"); else n_pass++;
    cyc = 0;
    repeat (2) begin
      @(negedge clk_in);
      cyc++;
    end
    n_total++; if (u_mm.counter !== 3'd2) $display("FAIL st_at_rise got %0d want 2", u_mm.counter); else n_pass++;
    r_pull_mm = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_in);
      cyc++;
      n_total++; if (u_mm.counter !== 3'd2) $display("FAIL st_hold cycle %0d got %0d want 2", i, u_mm.counter); else n_pass++;
      n_total++; if (bus_clear_mm !== 1'b0) $display("FAIL st_bus_clear cycle %0d got %b want 0", i, bus_clear_mm); else n_pass++;
    end
    r_pull_mm = 1'b0;
    @(negedge clk_in);
    cyc++;
    n_total++; if (u_mm.counter !== 3'd3) $display("FAIL st_resume got %0d want 3", u_mm.counter); else n_pass++;
    for (int i = 0; i < 10 && u_mm.counter != 0; i++) begin
      @(negedge clk_in);
      cyc++;
    end
    n_total++; if (cyc != 15) $display("FAIL st_period got %0d want 15", cyc); else n_pass++;
  endtask

  task automatic test_stuck;
    bit ok;
    wait_mm(2, ok);
    n_total++; if (!ok) $display("FAIL stuck_sync got timeout want counter=2"); else n_pass++;
    r_pull_mm = 1'b1;
    repeat (99) @(negedge clk_in);
    n_total++; if (bus_clear_mm !== 1'b0) $display("FAIL stuck_early got %b want 0 after 99", bus_clear_mm); else n_pass++;
    @(negedge clk_in);
    n_total++; if (bus_clear_mm !== 1'b1) $display("FAIL stuck_rise got %b want 1 after 100", bus_clear_mm); else n_pass++;
    repeat (20) @(negedge clk_in);
    n_total++; if (bus_clear_mm !== 1'b1 || u_mm.counter !== 3'd2) $display("FAIL stuck_hold got bc=%b cnt=%0d want bc=1 cnt=2", bus_clear_mm, u_mm.counter); else n_pass++;
    r_pull_mm = 1'b0;
    @(negedge clk_in);
    n_total++; if (bus_clear_mm !== 1'b0) $display("FAIL stuck_fall got %b want 0", bus_clear_mm); else n_pass++;
    n_total++; if (u_mm.counter !== 3'd3) $display("FAIL stuck_resume got %0d want 3", u_mm.counter); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_reset_mid;
    test_multi_master;
    test_stretch;
    test_stuck;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
